// File: rtl/ddr2_rw_cmd_pkg.sv
// Shared DDR2 controller constants: command encodings, bus widths,
// one-hot sequencer state codes and the wait-counter load helper.
package ddr2_rw_cmd_pkg;

  localparam int DDR2_BA_BITS   = 3;
  localparam int DDR2_ADDR_BITS = 13;
  localparam int CNT_W          = 4;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;

  typedef enum logic [6:0] {
    S_IDLE     = 7'b0000001,
    S_ACT      = 7'b0000010,
    S_WAIT_RCD = 7'b0000100,
    S_RW       = 7'b0001000,
    S_WAIT_PRE = 7'b0010000,
    S_PRE      = 7'b0100000,
    S_WAIT_RP  = 7'b1000000
  } state_t;

  function automatic logic [CNT_W-1:0] ld_val(input int t);
    return CNT_W'(t - 1);
  endfunction

endpackage

// File: rtl/ddr2_rw_cmd_wait_cnt.sv
// 4-bit loadable down-counter with zero flag; holds at zero.
// Shared by the rw sequencer and the refresh block.
module ddr2_rw_cmd_wait_cnt
  import ddr2_rw_cmd_pkg::*;
(
  input  logic             ck,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (!zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ddr2_rw_cmd.sv
// Single-access DDR2 read/write sequencer: ACT, RD/WR, PRE with
// programmable NOP gaps and a one-cycle end pulse.
module ddr2_rw_cmd
  import ddr2_rw_cmd_pkg::*;
#(
  parameter int BA_BITS   = DDR2_BA_BITS,
  parameter int ADDR_BITS = DDR2_ADDR_BITS,
  parameter int COL_BITS  = 10,
  parameter int T_RCD     = 3,
  parameter int T_WR2PRE  = 8,
  parameter int T_RD2PRE  = 4,
  parameter int T_RP      = 3
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 rw_en,
  input  logic                 rw_we,
  input  logic [BA_BITS-1:0]   rw_bank,
  input  logic [ADDR_BITS-1:0] rw_row,
  input  logic [COL_BITS-1:0]  rw_col,
  output logic [3:0]           rw_cmd,
  output logic [BA_BITS-1:0]   rw_ba,
  output logic [ADDR_BITS-1:0] rw_addr,
  output logic                 rw_busy,
  output logic                 rw_wr_start,
  output logic                 rw_rd_start,
  output logic                 rw_end
);

  localparam logic [CNT_W-1:0] RCD_LD = ld_val(T_RCD);
  localparam logic [CNT_W-1:0] WR_LD  = ld_val(T_WR2PRE);
  localparam logic [CNT_W-1:0] RD_LD  = ld_val(T_RD2PRE);
  localparam logic [CNT_W-1:0] RP_LD  = ld_val(T_RP);

  state_t                state;
  logic                  we_q;
  logic [BA_BITS-1:0]    bank_q;
  logic [COL_BITS-1:0]   col_q;
  logic [ADDR_BITS-1:0]  col_addr;
  logic                  cnt_load;
  logic [CNT_W-1:0]      cnt_val;
  logic [CNT_W-1:0]      cnt;
  logic                  cnt_zero;

  // A10 stays low: no auto-precharge
  assign col_addr = {{(ADDR_BITS-COL_BITS){1'b0}}, col_q};
  assign rw_busy  = (state != S_IDLE);

  // Load on entry to the state whose gap the counter times
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (state == S_IDLE && rw_en) begin
      cnt_load = 1'b1;
      cnt_val  = RCD_LD;
    end else if ((state == S_ACT || state == S_WAIT_RCD)
                 && cnt_zero) begin
      cnt_load = 1'b1;
      cnt_val  = we_q ? WR_LD : RD_LD;
    end else if (state == S_PRE) begin
      cnt_load = 1'b1;
      cnt_val  = RP_LD;
    end
  end

  ddr2_rw_cmd_wait_cnt u_cnt (
    .ck       (ck),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      we_q        <= 1'b0;
      bank_q      <= '0;
      col_q       <= '0;
      rw_cmd      <= CMD_NOP;
      rw_ba       <= '0;
      rw_addr     <= '0;
      rw_wr_start <= 1'b0;
      rw_rd_start <= 1'b0;
      rw_end      <= 1'b0;
    end else begin
      rw_cmd      <= CMD_NOP;
      rw_ba       <= '0;
      rw_addr     <= '0;
      rw_wr_start <= 1'b0;
      rw_rd_start <= 1'b0;
      rw_end      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (rw_en) begin
            we_q    <= rw_we;
            bank_q  <= rw_bank;
            col_q   <= rw_col;
            state   <= S_ACT;
            rw_cmd  <= CMD_ACT;
            rw_ba   <= rw_bank;
            rw_addr <= rw_row;
          end
        end
        S_ACT, S_WAIT_RCD: begin
          if (cnt_zero) begin
            state       <= S_RW;
            rw_cmd      <= we_q ? CMD_WRITE : CMD_READ;
            rw_ba       <= bank_q;
            rw_addr     <= col_addr;
            rw_wr_start <= we_q;
            rw_rd_start <= !we_q;
          end else begin
            state <= S_WAIT_RCD;
          end
        end
        S_RW, S_WAIT_PRE: begin
          if (cnt_zero) begin
            state  <= S_PRE;
            rw_cmd <= CMD_PRE;
            rw_ba  <= bank_q;
          end else begin
            state <= S_WAIT_PRE;
          end
        end
        S_PRE: begin
          state  <= S_WAIT_RP;
          rw_end <= (RP_LD == '0);
        end
        S_WAIT_RP: begin
          if (cnt_zero) begin
            state <= S_IDLE;
          end else begin
            rw_end <= (cnt == CNT_W'(1));
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_rw_cmd.sv
// Bench for ddr2_rw_cmd: directed and randomized sequences checked
// against a cycle-schedule model derived from the timing parameters.
module tb_ddr2_rw_cmd;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;

  logic ck = 1'b0;
  logic rst = 1'b1;
  always #5 ck = ~ck;

  logic        en0, en1, rw_we;
  logic [2:0]  rw_bank;
  logic [12:0] rw_row;
  logic [9:0]  rw_col;

  logic [3:0]  cmd0, cmd1;
  logic [2:0]  ba0, ba1;
  logic [12:0] addr0, addr1;
  logic        busy0, busy1, wrs0, wrs1, rds0, rds1, end0, end1;

  int checks = 0;
  int errors = 0;

  ddr2_rw_cmd dut (
    .ck(ck), .rst(rst), .rw_en(en0), .rw_we(rw_we),
    .rw_bank(rw_bank), .rw_row(rw_row), .rw_col(rw_col),
    .rw_cmd(cmd0), .rw_ba(ba0), .rw_addr(addr0),
    .rw_busy(busy0), .rw_wr_start(wrs0),
    .rw_rd_start(rds0), .rw_end(end0)
  );

  ddr2_rw_cmd #(
    .T_RCD(1), .T_WR2PRE(1), .T_RD2PRE(1), .T_RP(1)
  ) dut_min (
    .ck(ck), .rst(rst), .rw_en(en1), .rw_we(rw_we),
    .rw_bank(rw_bank), .rw_row(rw_row), .rw_col(rw_col),
    .rw_cmd(cmd1), .rw_ba(ba1), .rw_addr(addr1),
    .rw_busy(busy1), .rw_wr_start(wrs1),
    .rw_rd_start(rds1), .rw_end(end1)
  );

  task automatic chk(input string tag, input int c,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d obs=%0h exp=%0h",
             tag, c, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit en,
                       input bit we, input logic [2:0] b,
                       input logic [12:0] r,
                       input logic [9:0] c);
    en0     = en && !sel;
    en1     = en && sel;
    rw_we   = we;
    rw_bank = b;
    rw_row  = r;
    rw_col  = c;
  endtask

  task automatic drive_rand(input bit sel, input bit en);
    drive(sel, en, 1'($urandom), 3'($urandom),
          13'($urandom), 10'($urandom));
  endtask

  // noise: 0 none, 1 random grants, 2 grants at cycle 5
  // and in the end cycle, 3 grant held high throughout
  task automatic run(input bit sel, input bit we,
                     input logic [2:0] b,
                     input logic [12:0] r,
                     input logic [9:0] col,
                     input int noise);
    int rcd, x2p, rp, t_rw, t_pre, t_end;
    logic [3:0]  ecmd, ocmd;
    logic [2:0]  oba;
    logic [12:0] oaddr;
    logic        obusy, owr, ord, oend;
    bit          g;
    rcd   = sel ? 1 : 3;
    x2p   = sel ? 1 : (we ? 8 : 4);
    rp    = sel ? 1 : 3;
    t_rw  = 1 + rcd;
    t_pre = t_rw + x2p;
    t_end = t_pre + rp;
    for (int c = 0; c <= t_end; c++) begin
      if (c == 0) begin
        drive(sel, 1'b1, we, b, r, col);
      end else begin
        case (noise)
          1: g = ($urandom_range(0, 2) == 0);
          2: g = (c == 5) || (c == t_end);
          3: g = 1'b1;
          default: g = 1'b0;
        endcase
        drive_rand(sel, g);
      end
      @(negedge ck);
      ocmd  = sel ? cmd1 : cmd0;
      oba   = sel ? ba1 : ba0;
      oaddr = sel ? addr1 : addr0;
      obusy = sel ? busy1 : busy0;
      owr   = sel ? wrs1 : wrs0;
      ord   = sel ? rds1 : rds0;
      oend  = sel ? end1 : end0;
      if (c == 1) ecmd = ACT;
      else if (c == t_rw) ecmd = we ? WR : RD;
      else if (c == t_pre) ecmd = PRE;
      else ecmd = NOP;
      chk("cmd", c, 32'(ocmd), 32'(ecmd));
      chk("busy", c, 32'(obusy), 32'(c >= 1));
      chk("strobes", c, 32'({owr, ord, oend}),
          32'({c == t_rw && we, c == t_rw && !we,
               c == t_end}));
      if (c == 1)
        chk("act_ba_addr", c, 32'({oba, oaddr}),
            32'({b, r}));
      if (c == t_rw)
        chk("rw_ba_addr", c, 32'({oba, oaddr}),
            32'({b, 3'b000, col}));
      if (c == t_pre)
        chk("pre_ba_addr", c, 32'({oba, oaddr}),
            32'({b, 13'h0}));
      @(posedge ck);
      #1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive_rand(1'b0, 1'b0);
      @(negedge ck);
      chk("idle_cmd", i, 32'({cmd0, cmd1}), 32'({NOP, NOP}));
      chk("idle_busy", i, 32'({busy0, busy1, end0, end1}),
          32'(0));
      @(posedge ck);
      #1;
    end
  endtask

  initial begin
    bit sel, psel, we;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(posedge ck);
    @(negedge ck);
    chk("rst_cmd", 0, 32'({cmd0, cmd1}), 32'({NOP, NOP}));
    chk("rst_ba_addr", 0, 32'({ba0, addr0, ba1, addr1}),
        32'(0));
    chk("rst_flags", 0,
        32'({busy0, wrs0, rds0, end0, busy1, wrs1, rds1, end1}),
        32'(0));
    @(posedge ck);
    #1 rst = 1'b0;

    // default write and read
    run(1'b0, 1'b1, 3'd2, 13'h1A5, 10'h03F, 0);
    idle(1);
    run(1'b0, 1'b0, 3'd7, 13'h1FFF, 10'h3FF, 0);
    idle(1);

    // grants at cycle 5 and in the end cycle are ignored
    run(1'b0, 1'b1, 3'd4, 13'h0C3, 10'h155, 2);
    idle(3);
    run(1'b0, 1'b0, 3'd1, 13'h1234, 10'h2AA, 2);
    idle(3);

    // minimum timing
    run(1'b1, 1'b1, 3'd3, 13'h0F0, 10'h00F, 0);
    run(1'b1, 1'b0, 3'd6, 13'h1111, 10'h3C0, 0);
    idle(1);

    // back-to-back with rw_en held high
    run(1'b0, 1'b1, 3'd5, 13'h0AAA, 10'h111, 3);
    run(1'b0, 1'b0, 3'd0, 13'h1555, 10'h222, 3);
    run(1'b0, 1'b1, 3'd3, 13'h0077, 10'h333, 0);
    idle(1);

    // reset while in WAIT_RCD
    drive(1'b0, 1'b1, 1'b1, 3'd5, 13'h0AA, 10'h155);
    @(posedge ck);
    #1 drive_rand(1'b0, 1'b0);
    @(posedge ck);
    #1 drive_rand(1'b0, 1'b0);
    @(negedge ck);
    chk("wait_rcd", 2, 32'({cmd0, busy0}), 32'({NOP, 1'b1}));
    #1 rst = 1'b1;
    #1;
    chk("async_rst", 2, 32'({cmd0, busy0, ba0, addr0}),
        32'({NOP, 1'b0, 3'd0, 13'd0}));
    @(posedge ck);
    #1;
    chk("held_rst", 3,
        32'({cmd0, busy0, wrs0, rds0, end0, ba0, addr0}),
        32'({NOP, 4'b0000, 3'd0, 13'd0}));
    rst = 1'b0;
    run(1'b0, 1'b0, 3'd6, 13'h0ABC, 10'h0DE, 0);
    idle(1);

    // randomized requests
    psel = 1'b0;
    for (int i = 0; i < 30; i++) begin
      sel = 1'($urandom);
      we  = 1'($urandom);
      if (sel != psel || $urandom_range(0, 1) == 1)
        idle($urandom_range(1, 3));
      run(sel, we, 3'($urandom), 13'($urandom),
          10'($urandom), $urandom_range(0, 1));
      psel = sel;
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
